serial_add_ctrl: RTL and testbench

Multi-cycle add/subtract controller that computes a WIDTH-bit sum by sequencing one 4-bit ripple-adder slice over WIDTH/4 cycles, least-significant nibble first, and carries between slices in a register. It sits in the ALU path as the area-minimal adder for low-rate operations such as address offsets and loop counters. Requests and results use valid/ready handshakes. Results include carry, signed-overflow and zero flags.

---
 rtl/serial_add_ctrl_pkg.sv | 19 +
 rtl/adder_slice4.sv | 29 ++
 rtl/serial_add_ctrl.sv | 161 ++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared ALU package for the serial add/subtract controller.
// Provides the controller state enum, the slice width, and the helper that
// sizes the slice index register.
package serial_add_ctrl_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Slice index width; never narrower than one bit
   function automatic int unsigned idx_width(input int unsigned nslice);
      return (nslice <= 2) ? 1 : $clog2(nslice);
   endfunction

endpackage

// File: rtl/adder_slice4.sv
// Purely combinational 4-bit ripple-carry adder slice.
// Ports: a, b  - 4-bit addends
//        cin   - carry in
//        sum   - 4-bit sum
//        cout  - carry out of bit 3
module adder_slice4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry_c;

   // Ripple the carry bit by bit
   always_comb begin
      carry_c    = '0;
      sum        = '0;
      carry_c[0] = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i]       = a[i] ^ b[i] ^ carry_c[i];
         carry_c[i+1] = (a[i] & b[i]) | (a[i] & carry_c[i]) | (b[i] & carry_c[i]);
      end
   end

   assign cout = carry_c[4];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle add/subtract controller: one 4-bit slice per cycle, LSB nibble
// first, carry held in a register between slices.
// Ports: clk, rst_n                       - clock, async active-low reset
//        req_valid/req_ready              - request handshake
//        req_a, req_b, req_sub            - operands and op select (1 = A-B)
//        flush                            - synchronous abort of RUN/DONE
//        resp_valid/resp_ready            - response handshake
//        resp_sum, resp_cout, resp_ovf, resp_zero - registered result + flags
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_sub,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_sum,
   output logic             resp_cout,
   output logic             resp_ovf,
   output logic             resp_zero
);

   localparam int unsigned NSLICE = WIDTH / SLICE_W;
   localparam int unsigned IDX_W  = idx_width(NSLICE);
   localparam int unsigned BASE_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_e             state_q;
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic               req_ready_q;
   logic               resp_valid_q;
   logic [WIDTH-1:0]   resp_sum_q;
   logic               resp_cout_q;
   logic               resp_ovf_q;
   logic               resp_zero_q;

   logic [BASE_W-1:0]  base_c;
   logic [SLICE_W-1:0] slice_a_c;
   logic [SLICE_W-1:0] slice_b_c;
   logic [SLICE_W-1:0] slice_sum_c;
   logic               slice_cout_c;
   logic [WIDTH-1:0]   resp_sum_d;
   logic               last_c;
   logic               ovf_c;

   // Bit offset of the current slice
   assign base_c    = BASE_W'(idx_q) * BASE_W'(SLICE_W);
   assign slice_a_c = op_a_q[base_c +: SLICE_W];
   assign slice_b_c = op_b_q[base_c +: SLICE_W];
   assign last_c    = (idx_q == LAST_IDX);

   adder_slice4 u_slice (
      .a    (slice_a_c),
      .b    (slice_b_c),
      .cin  (carry_q),
      .sum  (slice_sum_c),
      .cout (slice_cout_c)
   );

   // Result with the current slice merged in; used for final-slice flags
   always_comb begin
      resp_sum_d                    = resp_sum_q;
      resp_sum_d[base_c +: SLICE_W] = slice_sum_c;
   end

   // op_b_q already holds ~B for subtract, so one overflow rule covers both ops
   assign ovf_c = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                  (resp_sum_d[WIDTH-1] != op_a_q[WIDTH-1]);

   // Controller FSM with datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         carry_q      <= 1'b0;
         idx_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_sum_q   <= '0;
         resp_cout_q  <= 1'b0;
         resp_ovf_q   <= 1'b0;
         resp_zero_q  <= 1'b0;
      end else if (flush && (state_q != IDLE)) begin
         // Abort: discard everything and present cleared outputs
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         carry_q      <= 1'b0;
         idx_q        <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_sum_q   <= '0;
         resp_cout_q  <= 1'b0;
         resp_ovf_q   <= 1'b0;
         resp_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // flush in IDLE blocks acceptance
               if (req_valid && req_ready_q && !flush) begin
                  state_q     <= RUN;
                  req_ready_q <= 1'b0;
                  op_a_q      <= req_a;
                  op_b_q      <= req_sub ? ~req_b : req_b;
                  carry_q     <= req_sub;
                  idx_q       <= '0;
                  resp_sum_q  <= '0;
                  resp_cout_q <= 1'b0;
                  resp_ovf_q  <= 1'b0;
                  resp_zero_q <= 1'b0;
               end
            end
            RUN: begin
               resp_sum_q <= resp_sum_d;
               carry_q    <= slice_cout_c;
               if (last_c) begin
                  // Index parks at the last slice until DONE is left
                  state_q      <= DONE;
                  resp_valid_q <= 1'b1;
                  resp_cout_q  <= slice_cout_c;
                  resp_ovf_q   <= ovf_c;
                  resp_zero_q  <= (resp_sum_d == '0);
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            DONE: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  idx_q        <= '0;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_sum   = resp_sum_q;
   assign resp_cout  = resp_cout_q;
   assign resp_ovf   = resp_ovf_q;
   assign resp_zero  = resp_zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH = 32): directed vector table,
// randomized operations against an arithmetic reference model, and hand-written
// sequences for backpressure, flush and mid-operation reset.
module tb_serial_add_ctrl;

   localparam int unsigned WIDTH  = 32;
   localparam int          NSLICE = WIDTH / 4;

   logic             clk;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             req_sub;
   logic             flush;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_sum;
   logic             resp_cout;
   logic             resp_ovf;
   logic             resp_zero;

   int checks = 0;
   int errors = 0;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_sum   (resp_sum),
      .resp_cout  (resp_cout),
      .resp_ovf   (resp_ovf),
      .resp_zero  (resp_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands
   task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                            output logic [31:0] s, output logic c, output logic o,
                            output logic z);
      longint sa;
      longint sb;
      longint r;
      longint ua;
      longint ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      r  = sub ? (sa - sb) : (sa + sb);
      o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      s  = sub ? (a - b) : (a + b);
      c  = sub ? (ua >= ub) : ((ua + ub) > 64'sd4294967295);
      z  = (s == 32'd0);
   endtask

   // Handshake on the next edge, then scramble the request inputs
   task automatic start_req(input logic [31:0] a, input logic [31:0] b, input logic sub);
      req_a     = a;
      req_b     = b;
      req_sub   = sub;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a     = $urandom;
      req_b     = $urandom;
      req_sub   = 1'($urandom);
   endtask

   // Edges after the handshake until resp_valid is seen (bounded)
   task automatic wait_valid(output int n);
      n = 0;
      while (!resp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input int hold, input string tag);
      logic [31:0] es;
      logic        ec, eo, ez;
      int          lat;
      ref_model(a, b, sub, es, ec, eo, ez);
      check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
      start_req(a, b, sub);
      wait_valid(lat);
      check({tag, "_latency"}, 64'(lat), 64'(NSLICE));
      check({tag, "_sum"},  64'(resp_sum),  64'(es));
      check({tag, "_cout"}, 64'(resp_cout), 64'(ec));
      check({tag, "_ovf"},  64'(resp_ovf),  64'(eo));
      check({tag, "_zero"}, 64'(resp_zero), 64'(ez));
      repeat (hold) begin @(posedge clk); #1; end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, "_valid_drop"}, 64'(resp_valid), 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner [6];
      corner[0] = 32'h0000_0000;
      corner[1] = 32'hFFFF_FFFF;
      corner[2] = 32'h8000_0000;
      corner[3] = 32'h7FFF_FFFF;
      corner[4] = 32'h0000_0001;
      corner[5] = 32'h0000_000F;
      if ($urandom_range(3) == 0) return corner[$urandom_range(5)];
      return $urandom;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t        vecs [5];
      logic [31:0] snap_sum;
      logic        snap_c, snap_o, snap_z;
      logic [31:0] es;
      logic        ec, eo, ez;
      int          lat;
      bit          seen;

      vecs[0] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_sub = 1'b0;
      flush = 1'b0; resp_ready = 1'b0;
      #12;
      check("rst_req_ready",  64'(req_ready),  64'd1);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_sum",        64'(resp_sum),   64'd0);
      check("rst_flags",      64'({resp_cout, resp_ovf, resp_zero}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors
      for (int i = 0; i < 5; i++) begin
         req_a = vecs[i].a; req_b = vecs[i].b; req_sub = vecs[i].sub;
         check("vec_req_ready", 64'(req_ready), 64'd1);
         start_req(vecs[i].a, vecs[i].b, vecs[i].sub);
         wait_valid(lat);
         check("vec_latency", 64'(lat),       64'(NSLICE));
         check("vec_sum",     64'(resp_sum),  64'(vecs[i].sum));
         check("vec_cout",    64'(resp_cout), 64'(vecs[i].cout));
         check("vec_ovf",     64'(resp_ovf),  64'(vecs[i].ovf));
         check("vec_zero",    64'(resp_zero), 64'(vecs[i].zero));
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
         check("vec_valid_drop", 64'(resp_valid), 64'd0);
         check("vec_ready_back", 64'(req_ready),  64'd1);
      end

      // Backpressure in DONE with a competing request offered
      ref_model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, es, ec, eo, ez);
      start_req(32'h1234_5678, 32'h0FED_CBA9, 1'b1);
      wait_valid(lat);
      check("bp_latency", 64'(lat), 64'(NSLICE));
      check("bp_sum", 64'(resp_sum), 64'(es));
      snap_sum = resp_sum; snap_c = resp_cout; snap_o = resp_ovf; snap_z = resp_zero;
      req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid_hold", 64'(resp_valid), 64'd1);
         check("bp_sum_hold",   64'(resp_sum),   64'(snap_sum));
         check("bp_flag_hold",  64'({resp_cout, resp_ovf, resp_zero}),
               64'({snap_c, snap_o, snap_z}));
         check("bp_req_ready",  64'(req_ready),  64'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("bp_release_valid", 64'(resp_valid), 64'd0);
      check("bp_release_ready", 64'(req_ready),  64'd1);

      // Request inputs change every RUN cycle; result must use captured values
      ref_model(32'h0000_00FF, 32'h0000_0101, 1'b0, es, ec, eo, ez);
      start_req(32'h0000_00FF, 32'h0000_0101, 1'b0);
      for (int i = 0; i < NSLICE; i++) begin
         req_a = $urandom; req_b = $urandom; req_sub = 1'($urandom);
         @(posedge clk); #1;
      end
      check("chg_valid", 64'(resp_valid), 64'd1);
      check("chg_sum",   64'(resp_sum),   64'(es));
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;

      // Reset asserted at RUN cycle 4
      start_req(32'hDEAD_BEEF, 32'h1111_1111, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("rstrun_valid", 64'(resp_valid), 64'd0);
      check("rstrun_sum",   64'(resp_sum),   64'd0);
      check("rstrun_flags", 64'({resp_cout, resp_ovf, resp_zero}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("rstrun_ready", 64'(req_ready), 64'd1);
      do_op(32'd3, 32'd4, 1'b0, 0, "post_rst");

      // Flush at RUN cycle 3
      start_req(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_run_ready", 64'(req_ready),  64'd1);
      check("flush_run_valid", 64'(resp_valid), 64'd0);
      check("flush_run_sum",   64'(resp_sum),   64'd0);
      seen = 1'b0;
      for (int i = 0; i < NSLICE + 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      check("flush_run_never_valid", 64'(seen), 64'd0);

      // Flush in DONE
      start_req(32'h0000_0002, 32'h0000_0003, 1'b0);
      wait_valid(lat);
      check("flush_done_latency", 64'(lat), 64'(NSLICE));
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_done_valid", 64'(resp_valid), 64'd0);
      check("flush_done_sum",   64'(resp_sum),   64'd0);
      check("flush_done_ready", 64'(req_ready),  64'd1);

      // Flush together with a request in IDLE: nothing accepted
      req_a = 32'd9; req_b = 32'd9; req_sub = 1'b0;
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      check("flush_idle_ready", 64'(req_ready), 64'd1);
      repeat (NSLICE + 2) begin @(posedge clk); #1; end
      check("flush_idle_no_result", 64'(resp_valid), 64'd0);

      // Back-to-back ops with resp_ready held high: interval NSLICE+2
      resp_ready = 1'b1;
      start_req(32'd10, 32'd20, 1'b0);
      lat = 1;
      while (!req_ready && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b2b_interval", 64'(lat), 64'(NSLICE + 2));
      resp_ready = 1'b0;
      do_op(32'd100, 32'd1, 1'b1, 0, "b2b_second");

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         do_op(pick_operand(), pick_operand(), 1'($urandom), int'($urandom_range(3)), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
